avalon_st_capture_sink: RTL and testbench
=========================================

# avalon_st_capture_sink

Parametrised Avalon-ST packet capture sink for the DE2 test environment. It accepts a stream from the Ethernet receive path, waits for an armed start-of-packet and stores one framed packet (SOP..EOP) in an internal RAM, then reports length and status. Captured words are read back through a synchronous read port, and a selected word can be shown on the board LEDs.

## Interface
- `WIDTH`, 32: data bus width in bits; multiple of 8, at least 16.
- `DEPTH`, 1024: capture RAM depth in words; power of two.
- `EMPTY_W`, `$clog2(WIDTH/8)`: width of `empty`.
- `AW`, `$clog2(DEPTH)`: address width.
- `LEN_W`, `$clog2(DEPTH*WIDTH/8)+1`: byte-count width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ready` out 1: sink ready.
- `data` in WIDTH: beat data.
- `valid` in 1: beat valid.
- `sop` in 1: start of packet.
- `eop` in 1: end of packet.
- `empty` in EMPTY_W: number of unused bytes in the EOP beat.
- `arm` in 1: single-cycle pulse that arms capture.
- `armed` out 1: waiting for SOP.
- `capturing` out 1: packet in progress.
- `done` out 1: capture complete; held until the next `arm`.
- `overflow` out 1: packet truncated at DEPTH words.
- `frame_err` out 1: SOP seen mid-packet.
- `pkt_words` out AW+1: number of words stored.
- `pkt_bytes` out LEN_W: number of valid bytes stored.
- `rd_addr` in AW: readback address.
- `rd_data` out WIDTH: readback data.
- `button0` in 1: LED select.
- `button1` in 1: LED half select.
- `LEDS` out 16: board LEDs.

## Operation
- `ready` is held at 1 in every state except during reset. The sink never backpressures. Beats are accepted when `valid && ready`.
- The FSM has four states:
  - IDLE: accepted beats are discarded. `arm` → ARMED.
  - ARMED: accepted beats without `sop` are discarded. An accepted beat with `sop` is written at address 0, then → CAPTURE; if `eop` is also set, → DONE instead.
  - CAPTURE: each accepted beat is written at `wr_ptr`, and `wr_ptr` increments.
    - Accepted `eop` → DONE.
    - Accepted `sop` (without `eop`) → set `frame_err`, restart at address 0 with this beat, stay in CAPTURE.
    - A beat written at address DEPTH-1 without `eop` → set `overflow`, → DONE. Later beats of that packet are discarded.
  - DONE: beats are discarded. `arm` clears `done`, `overflow`, `frame_err`, `pkt_words` and `pkt_bytes`, then → ARMED.
- `arm` in ARMED or CAPTURE is ignored.
- If `sop` and `eop` arrive together in CAPTURE, they are treated as a restart with a one-word packet → DONE, and `frame_err` is set.
- Byte count arithmetic:
  - `pkt_bytes` = `pkt_words`×(WIDTH/8) − `empty` sampled on the EOP beat.
  - On overflow, `empty` is treated as 0.
  - Computed at LEN_W bits with no wrap.
- Readback: `rd_data` = RAM[`rd_addr`]. Contents beyond `pkt_words` are stale and undefined after reset.
- Reset values: state IDLE; `ready`, `armed`, `capturing`, `done`, `overflow`, `frame_err` all 0; `pkt_words`, `pkt_bytes`, `wr_ptr` all 0; `rd_data` 0; `LEDS` 16'h5555.
- Reset asserted mid-capture aborts immediately. RAM contents are undefined after it.

## Timing
- A beat accepted at edge N is stored in RAM at edge N.
- Status is registered and takes effect one cycle after the edge that accepts the relevant beat:
  - `capturing` rises the cycle after SOP is accepted.
  - `done`, `pkt_words`, `pkt_bytes` are valid the cycle after EOP (or the overflow beat) is accepted.
- `armed` rises the cycle after `arm` is sampled.
- Readback latency is 1 cycle: `rd_addr` at edge N produces `rd_data` after edge N+1.
- A read of the address being written in the same cycle returns the old data.
- `LEDS` updates one cycle after `rd_data`.
- Back-to-back beats run at one per cycle with no bubbles required.

## Configuration
- `CAPTURE_SINK_LED_EN` defined:
  - `LEDS` shows the 16-bit slice of `rd_data` chosen by `button1` (0 → [15:0], 1 → [31:16]; for WIDTH=16, [15:0] always) while `button0`=1.
  - While `button0`=0, `LEDS` shows the status pattern {`done`, `overflow`, `frame_err`, `capturing`, `armed`, 11'b0}.
- Undefined: `LEDS` is held at 16'h5555 and both buttons are ignored. All other behaviour is identical.

## Structure
- Package `capture_sink_pkg` holds:
  - the state enum `cap_state_t` (IDLE, ARMED, CAPTURE, DONE);
  - the localparam `LED_IDLE_PATTERN` = 16'h5555;
  - the function `calc_bytes(words, empty)`.
- Sub-module `capture_ram`: simple dual-port RAM with one write port, one registered read port and no reset on the array. Parametrised by `ADDR_WIDTH` and `DATA_WIDTH`; must infer M4K block RAM.

## Test plan
- Arm, then send a 4-beat packet of 32'h11111111..32'h44444444 with `empty`=2 on EOP → `done`=1, `pkt_words`=4, `pkt_bytes`=14; reading addresses 0..3 returns the 4 words in order.
- Send 3 beats before `arm`, then arm, then send a non-SOP beat followed by a 2-beat packet → only the 2-beat packet is stored; `pkt_words`=2.
- With DEPTH=16, send a 20-beat packet → `overflow`=1, `pkt_words`=16, `pkt_bytes`=64, address 15 holds beat 16.
- In CAPTURE after 3 beats, send a new SOP followed by 2 more beats with EOP → `frame_err`=1, `pkt_words`=3, address 0 holds the new SOP word.
- Drop `rst_n` asynchronously mid-packet → all status outputs are 0 immediately and the state is IDLE; after release, a new arm and capture completes normally.
- With `CAPTURE_SINK_LED_EN`: `button0`=1, `button1`=1, `rd_addr`=0 holding 32'hABCD1234 → `LEDS`=16'hABCD two cycles later. Without the macro → `LEDS`=16'h5555 throughout.

Source files
------------

// File: rtl/capture_sink_pkg.sv
// Shared types, constants and byte-count helper for the Avalon-ST capture sink.
package capture_sink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam logic [15:0] LED_IDLE_PATTERN = 16'h5555;

  // Valid bytes in a packet of `words` beats whose last beat has `empty_bytes` unused.
  function automatic logic [31:0] calc_bytes(input logic [31:0] words,
                                             input logic [31:0] empty_bytes,
                                             input logic [31:0] bytes_per_word = 32'd4);
    return (words * bytes_per_word) - empty_bytes;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture RAM: one write port, registered read port returning old data on collision.
module capture_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is cleared; the array itself has no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/avalon_st_capture_sink.sv
// Avalon-ST single-packet capture sink with readback port and optional LED view.
// Optional feature: define CAPTURE_SINK_LED_EN to drive LEDS from readback data / status.
module avalon_st_capture_sink
  import capture_sink_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned EMPTY_W = $clog2(WIDTH/8),
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned LEN_W   = $clog2(DEPTH*WIDTH/8)+1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ready,
  input  logic [WIDTH-1:0]   data,
  input  logic               valid,
  input  logic               sop,
  input  logic               eop,
  input  logic [EMPTY_W-1:0] empty,
  input  logic               arm,
  output logic               armed,
  output logic               capturing,
  output logic               done,
  output logic               overflow,
  output logic               frame_err,
  output logic [AW:0]        pkt_words,
  output logic [LEN_W-1:0]   pkt_bytes,
  input  logic [AW-1:0]      rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  input  logic               button0,
  input  logic               button1,
  output logic [15:0]        LEDS
);

  localparam int unsigned BPW       = WIDTH/8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

  cap_state_t        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              done_d, overflow_d, frame_err_d;
  logic [AW:0]       words_d;
  logic [LEN_W-1:0]  bytes_d;
  logic              accept_c, we_c;
  logic [AW-1:0]     waddr_c;
  logic [AW:0]       next_words_c;

  assign accept_c     = valid && ready;
  assign next_words_c = (AW+1)'(wr_ptr_q) + (AW+1)'(1);

  // Next-state and status update
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    done_d      = done;
    overflow_d  = overflow;
    frame_err_d = frame_err;
    words_d     = pkt_words;
    bytes_d     = pkt_bytes;
    we_c        = 1'b0;
    waddr_c     = wr_ptr_q;

    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (accept_c && sop) begin
          we_c    = 1'b1;
          waddr_c = '0;
          if (eop) begin
            state_d = DONE;
            done_d  = 1'b1;
            words_d = (AW+1)'(1);
            bytes_d = LEN_W'(calc_bytes(32'd1, 32'(empty), 32'(BPW)));
          end else begin
            state_d  = CAPTURE;
            wr_ptr_d = AW'(1);
          end
        end
      end
      CAPTURE: begin
        if (accept_c) begin
          we_c = 1'b1;
          if (sop) begin
            // New SOP mid-packet: restart the capture with this beat at address 0.
            frame_err_d = 1'b1;
            waddr_c     = '0;
            if (eop) begin
              state_d = DONE;
              done_d  = 1'b1;
              words_d = (AW+1)'(1);
              bytes_d = LEN_W'(calc_bytes(32'd1, 32'(empty), 32'(BPW)));
            end else begin
              wr_ptr_d = AW'(1);
            end
          end else if (eop) begin
            state_d = DONE;
            done_d  = 1'b1;
            words_d = next_words_c;
            bytes_d = LEN_W'(calc_bytes(32'(next_words_c), 32'(empty), 32'(BPW)));
          end else if (wr_ptr_q == LAST_ADDR) begin
            state_d    = DONE;
            done_d     = 1'b1;
            overflow_d = 1'b1;
            words_d    = next_words_c;
            bytes_d    = LEN_W'(calc_bytes(32'(next_words_c), 32'd0, 32'(BPW)));
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      DONE: begin
        if (arm) begin
          state_d     = ARMED;
          wr_ptr_d    = '0;
          done_d      = 1'b0;
          overflow_d  = 1'b0;
          frame_err_d = 1'b0;
          words_d     = '0;
          bytes_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      ready     <= 1'b0;
      armed     <= 1'b0;
      capturing <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      pkt_words <= '0;
      pkt_bytes <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      ready     <= 1'b1;
      armed     <= (state_d == ARMED);
      capturing <= (state_d == CAPTURE);
      done      <= done_d;
      overflow  <= overflow_d;
      frame_err <= frame_err_d;
      pkt_words <= words_d;
      pkt_bytes <= bytes_d;
    end
  end

  capture_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef CAPTURE_SINK_LED_EN
  logic [15:0] led_hi_c;

  if (WIDTH >= 32) begin : g_led_hi
    assign led_hi_c = rd_data[31:16];
  end else begin : g_led_lo
    assign led_hi_c = rd_data[15:0];
  end

  // Button 0 selects readback view, otherwise the status pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       LEDS <= LED_IDLE_PATTERN;
    else if (button0) LEDS <= button1 ? led_hi_c : rd_data[15:0];
    else              LEDS <= {done, overflow, frame_err, capturing, armed, 11'b0};
  end
`else
  logic unused_buttons;

  assign unused_buttons = ^{button0, button1};
  assign LEDS           = LED_IDLE_PATTERN;
`endif

endmodule

// File: tb/tb_avalon_st_capture_sink.sv
// Directed self-checking bench for avalon_st_capture_sink (WIDTH=32, DEPTH=16).
module tb_avalon_st_capture_sink;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned EMPTY_W = 2;
  localparam int unsigned AW      = 4;
  localparam int unsigned LEN_W   = 7;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ready;
  logic [WIDTH-1:0]   data;
  logic               valid, sop, eop, arm;
  logic [EMPTY_W-1:0] empty;
  logic               armed, capturing, done, overflow, frame_err;
  logic [AW:0]        pkt_words;
  logic [LEN_W-1:0]   pkt_bytes;
  logic [AW-1:0]      rd_addr;
  logic [WIDTH-1:0]   rd_data;
  logic               button0, button1;
  logic [15:0]        LEDS;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  avalon_st_capture_sink #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .EMPTY_W(EMPTY_W), .AW(AW), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .data(data), .valid(valid),
    .sop(sop), .eop(eop), .empty(empty), .arm(arm), .armed(armed),
    .capturing(capturing), .done(done), .overflow(overflow), .frame_err(frame_err),
    .pkt_words(pkt_words), .pkt_bytes(pkt_bytes), .rd_addr(rd_addr), .rd_data(rd_data),
    .button0(button0), .button1(button1), .LEDS(LEDS)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
    @(negedge clk);
    valid = 1'b1; data = d; sop = s; eop = e; empty = emp; arm = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0; empty = '0; arm = 1'b0;
  endtask

  task automatic do_arm();
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check(tag, rd_data, exp);
  endtask

  logic [15:0] exp_led;

  initial begin
    rst_n = 1'b0; data = '0; valid = 1'b0; sop = 1'b0; eop = 1'b0; empty = '0;
    arm = 1'b0; rd_addr = '0; button0 = 1'b0; button1 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_capturing", 32'(capturing), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words", 32'(pkt_words), 32'd0);
    check("rst_bytes", 32'(pkt_bytes), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_leds", 32'(LEDS), 32'h5555);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'd1);

    // Basic 4-beat packet with empty=2 on EOP
    do_arm();
    check("t1_armed", 32'(armed), 32'd1);
    beat(32'h11111111, 1'b1, 1'b0, 2'd0);
    beat(32'h22222222, 1'b0, 1'b0, 2'd0);
    check("t1_capturing", 32'(capturing), 32'd1);
    beat(32'h33333333, 1'b0, 1'b0, 2'd0);
    beat(32'h44444444, 1'b0, 1'b1, 2'd2);
    idle();
    check("t1_done", 32'(done), 32'd1);
    check("t1_capturing_off", 32'(capturing), 32'd0);
    check("t1_words", 32'(pkt_words), 32'd4);
    check("t1_bytes", 32'(pkt_bytes), 32'd14);
    read_chk("t1_rd0", 4'd0, 32'h11111111);
    read_chk("t1_rd1", 4'd1, 32'h22222222);
    read_chk("t1_rd2", 4'd2, 32'h33333333);
    read_chk("t1_rd3", 4'd3, 32'h44444444);

    // Beats before arm are dropped, non-SOP beat while armed is dropped
    beat(32'hBAD00001, 1'b1, 1'b0, 2'd0);
    beat(32'hBAD00002, 1'b0, 1'b0, 2'd0);
    beat(32'hBAD00003, 1'b0, 1'b1, 2'd0);
    idle();
    check("t2_words_kept", 32'(pkt_words), 32'd4);
    do_arm();
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_words_clr", 32'(pkt_words), 32'd0);
    check("t2_bytes_clr", 32'(pkt_bytes), 32'd0);
    beat(32'hDEAD0000, 1'b0, 1'b0, 2'd0);
    beat(32'h55550001, 1'b1, 1'b0, 2'd0);
    beat(32'h55550002, 1'b0, 1'b1, 2'd0);
    idle();
    check("t2_done", 32'(done), 32'd1);
    check("t2_words", 32'(pkt_words), 32'd2);
    check("t2_bytes", 32'(pkt_bytes), 32'd8);
    check("t2_ferr", 32'(frame_err), 32'd0);
    read_chk("t2_rd0", 4'd0, 32'h55550001);
    read_chk("t2_rd1", 4'd1, 32'h55550002);

    // Overflow: 20 beats into a 16-word RAM
    do_arm();
    for (int i = 1; i <= 20; i++)
      beat(32'h0F000000 + 32'(i), (i == 1), (i == 20), (i == 20) ? 2'd3 : 2'd0);
    idle();
    check("t3_done", 32'(done), 32'd1);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_words", 32'(pkt_words), 32'd16);
    check("t3_bytes", 32'(pkt_bytes), 32'd64);
    read_chk("t3_rd15", 4'd15, 32'h0F000010);
    read_chk("t3_rd0", 4'd0, 32'h0F000001);

    // Frame error: SOP after 3 beats restarts the packet
    do_arm();
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    beat(32'hA0000001, 1'b1, 1'b0, 2'd0);
    beat(32'hA0000002, 1'b0, 1'b0, 2'd0);
    beat(32'hA0000003, 1'b0, 1'b0, 2'd0);
    beat(32'hB0000001, 1'b1, 1'b0, 2'd0);
    beat(32'hB0000002, 1'b0, 1'b0, 2'd0);
    beat(32'hB0000003, 1'b0, 1'b1, 2'd1);
    idle();
    check("t4_ferr", 32'(frame_err), 32'd1);
    check("t4_words", 32'(pkt_words), 32'd3);
    check("t4_bytes", 32'(pkt_bytes), 32'd11);
    idle();
`ifdef CAPTURE_SINK_LED_EN
    exp_led = 16'hA000;
`else
    exp_led = 16'h5555;
`endif
    check("t4_leds_status", 32'(LEDS), 32'(exp_led));
    read_chk("t4_rd0", 4'd0, 32'hB0000001);
    read_chk("t4_rd2", 4'd2, 32'hB0000003);

    // SOP together with EOP while capturing: one-word restart
    do_arm();
    beat(32'hC0000001, 1'b1, 1'b0, 2'd0);
    beat(32'hC0000002, 1'b1, 1'b1, 2'd0);
    idle();
    check("t5_done", 32'(done), 32'd1);
    check("t5_ferr", 32'(frame_err), 32'd1);
    check("t5_words", 32'(pkt_words), 32'd1);
    check("t5_bytes", 32'(pkt_bytes), 32'd4);
    read_chk("t5_rd0", 4'd0, 32'hC0000002);

    // LED readback view of a single-beat packet
    do_arm();
    beat(32'hABCD1234, 1'b1, 1'b1, 2'd0);
    idle();
    check("t6_words", 32'(pkt_words), 32'd1);
    check("t6_ferr", 32'(frame_err), 32'd0);
    @(negedge clk);
    button0 = 1'b1; button1 = 1'b1; rd_addr = '0;
    repeat (2) @(negedge clk);
`ifdef CAPTURE_SINK_LED_EN
    exp_led = 16'hABCD;
`else
    exp_led = 16'h5555;
`endif
    check("t6_leds_hi", 32'(LEDS), 32'(exp_led));
    button1 = 1'b0;
    @(negedge clk);
`ifdef CAPTURE_SINK_LED_EN
    exp_led = 16'h1234;
`else
    exp_led = 16'h5555;
`endif
    check("t6_leds_lo", 32'(LEDS), 32'(exp_led));
    button0 = 1'b0;

    // Asynchronous reset mid-packet
    do_arm();
    beat(32'hE0000001, 1'b1, 1'b0, 2'd0);
    beat(32'hE0000002, 1'b0, 1'b0, 2'd0);
    beat(32'hE0000003, 1'b1, 1'b0, 2'd0);
    @(posedge clk);
    #2;
    check("t7_pre_ferr", 32'(frame_err), 32'd1);
    check("t7_pre_capturing", 32'(capturing), 32'd1);
    rst_n = 1'b0;
    valid = 1'b0; sop = 1'b0;
    #1;
    check("t7_ferr", 32'(frame_err), 32'd0);
    check("t7_capturing", 32'(capturing), 32'd0);
    check("t7_armed", 32'(armed), 32'd0);
    check("t7_done", 32'(done), 32'd0);
    check("t7_words", 32'(pkt_words), 32'd0);
    check("t7_ready", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_arm();
    check("t7_rearm", 32'(armed), 32'd1);
    beat(32'hF0000001, 1'b1, 1'b0, 2'd0);
    beat(32'hF0000002, 1'b0, 1'b1, 2'd0);
    idle();
    check("t7_done_after", 32'(done), 32'd1);
    check("t7_words_after", 32'(pkt_words), 32'd2);
    check("t7_bytes_after", 32'(pkt_bytes), 32'd8);
    read_chk("t7_rd1", 4'd1, 32'hF0000002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
